clk_div_nch: RTL and testbench

//  Multi-channel programmable clock divider / tick generator.
//  - NCH independent channels, each producing a 1-cycle tick strobe and a 50% square wave at clk/(2*div).
//  - Divisors are runtime-writable through a simple write port, with glitch-free reload at wrap.
//  - Feeds display scan, debounce sampling and 1 Hz timekeeping logic from the single board clock.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_chan.sv | 77 +++++++
 rtl/clk_div_nch.sv | 44 ++++
 tb/tb_clk_div_nch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-divider slice: default widths, 50 MHz divisor presets,
// the per-channel action encoding and the channel-select width helper.
package clk_div_pkg;

  localparam int CNT_W_DEF = 25;
  localparam int unsigned DIV_1HZ_50M = 25_000_000;
  localparam int unsigned DIV_1KHZ_50M = 25_000;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_COUNT,
    ACT_WRAP,
    ACT_RESTART
  } chan_act_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor pair, registered tick and square output.
// Outputs are registered (one edge after the wrap); the write port is always accepted, no backpressure.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DIV_1HZ_50M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  chan_act_e        act;

  // A halted channel (active==0) restarts on its own once a new divisor is pending.
  always_comb begin
    act = ACT_HOLD;
    if (active == '0) begin
      if (pend) act = ACT_RESTART;
    end else if (en) begin
      act = (cnt == active - CNT_W'(1)) ? ACT_WRAP : ACT_COUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= CNT_W'(DEF_DIV);
      shadow <= CNT_W'(DEF_DIV);
      pend   <= 1'b0;
      tick   <= 1'b0;
      sq     <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      tick   <= 1'b0;
      sq     <= 1'b0;
      pend   <= 1'b0;
      active <= wr ? wr_div : shadow;
      if (wr) shadow <= wr_div;
    end else begin
      tick <= (act == ACT_WRAP);
      case (act)
        ACT_COUNT: cnt <= cnt + CNT_W'(1);
        ACT_WRAP: begin
          cnt <= '0;
          sq  <= ~sq;
          if (pend) begin
            active <= shadow;
            pend   <= 1'b0;
          end
        end
        ACT_RESTART: begin
          cnt    <= '0;
          active <= shadow;
          pend   <= 1'b0;
        end
        default: ;
      endcase
      // A write landing on the apply edge stays pending for the next wrap.
      if (wr) begin
        shadow <= wr_div;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_nch.sv
// Multi-channel programmable tick / square-wave generator; outputs registered, one edge after wrap.
// Write port has no backpressure; writes to channels >= NCH are dropped.
module clk_div_nch
  import clk_div_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DIV_1HZ_50M,
  parameter int          CH_W    = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq_out,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] wr_sel;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr_sel[g] = wr_en && (int'(wr_ch) == g);

    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[g]),
      .clr   (clr),
      .wr    (wr_sel[g]),
      .wr_div(wr_div),
      .tick  (tick[g]),
      .sq    (sq_out[g]),
      .pend  (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_nch.sv
// Bench for clk_div_nch with NCH=2, CNT_W=8, DEF_DIV=4; vectors list outputs expected after each edge.
module tb_clk_div_nch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en = '0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_div = '0;
  logic [1:0] tick, sq_out, pend;

  always #5 clk = ~clk;

  clk_div_nch #(
    .NCH    (2),
    .CNT_W  (8),
    .DEF_DIV(4),
    .CH_W   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .wr_en (wr_en),
    .wr_ch (wr_ch),
    .wr_div(wr_div),
    .tick  (tick),
    .sq_out(sq_out),
    .pend  (pend)
  );

  typedef struct {
    logic [1:0] en;
    logic       clr;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [1:0] tick;
    logic [1:0] sq;
    logic [1:0] pend;
  } vec_t;

  typedef struct {
    logic [5:0] v;
    string      nm;
  } exp_t;

  vec_t  tbl[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  string sect;

  function automatic void add(input logic [1:0] e, input logic c, input logic w,
                              input logic [1:0] ch, input logic [7:0] d,
                              input logic [1:0] t, input logic [1:0] s, input logic [1:0] p);
    vec_t v;
    v.en = e; v.clr = c; v.wr_en = w; v.wr_ch = ch; v.wr_div = d;
    v.tick = t; v.sq = s; v.pend = p;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: tick/sq_out/pend got %b/%b/%b want %b/%b/%b",
               nm, act[5:4], act[3:2], act[1:0], req[5:4], req[3:2], req[1:0]);
    end
  endtask

  // Drives each vector at a falling edge, then compares after the following rising edge.
  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t x;
      en     = tbl[i].en;
      clr    = tbl[i].clr;
      wr_en  = tbl[i].wr_en;
      wr_ch  = tbl[i].wr_ch;
      wr_div = tbl[i].wr_div;
      x.v    = {tbl[i].tick, tbl[i].sq, tbl[i].pend};
      x.nm   = $sformatf("%s[%0d]", sect, i);
      exp_q.push_back(x);
      @(posedge clk);
      @(negedge clk);
      x = exp_q.pop_front();
      check(x.nm, {tick, sq_out, pend}, x.v);
    end
    tbl.delete();
    clr   = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_state", {tick, sq_out, pend}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default divisor 4: ticks after edges 4, 8, 12.
    sect = "s1_default";
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b11,2'b00);
    run_tbl();

    // ch1 <- 2 written at cnt=1, applied at the next wrap.
    sect = "s2_wr_ch1";
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,1,1,2, 2'b00,2'b11,2'b10);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b10);
    add(2'b11,0,0,0,0, 2'b11,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b00,2'b00);
    run_tbl();

    // ch0 paused at cnt=2 for 10 edges while ch1 keeps ticking every 2.
    sect = "s4_en_pause";
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b10,2'b00);
    for (int e = 27; e <= 36; e++) begin
      logic [1:0] t;
      logic [1:0] s;
      t = (e % 2 == 0) ? 2'b10 : 2'b00;
      s = {1'(((e / 2) % 2)), 1'b0};
      add(2'b10,0,0,0,0, t, s, 2'b00);
    end
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b11,2'b00);
    run_tbl();

    // ch0 <- 3 written on its wrap edge; out-of-range channel write ignored.
    sect = "s3_wr_on_wrap";
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b01,2'b00);
    add(2'b11,0,1,0,3, 2'b11,2'b10,2'b01);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b01);
    add(2'b11,0,1,3,1, 2'b10,2'b00,2'b01);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b01);
    add(2'b11,0,0,0,0, 2'b11,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b01,2'b00);
    run_tbl();

    // ch1 <- 0 halts after its wrap; ch1 <- 3 restarts it one edge after the write.
    sect = "s5_halt";
    add(2'b11,0,1,1,0, 2'b00,2'b01,2'b10);
    add(2'b11,0,0,0,0, 2'b10,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b11,2'b00);
    add(2'b11,0,1,1,3, 2'b00,2'b11,2'b10);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,1,0,2, 2'b10,2'b00,2'b01);
    run_tbl();

    // clr applies ch0's pending 2 and the concurrent ch1 <- 5.
    sect = "s6_clr";
    add(2'b11,1,1,1,5, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b10,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b10,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b01,2'b00);
    add(2'b11,0,0,0,0, 2'b01,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,1,1,7, 2'b01,2'b01,2'b10);
    run_tbl();

    // Asynchronous reset mid-count with a write pending.
    #1 rst_n = 1'b0;
    #1 check("async_reset", {tick, sq_out, pend}, 6'b0);
    @(negedge clk);
    check("reset_held", {tick, sq_out, pend}, 6'b0);
    rst_n = 1'b1;

    sect = "s6_after_reset";
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b00,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b00,2'b11,2'b00);
    add(2'b11,0,0,0,0, 2'b11,2'b00,2'b00);
    run_tbl();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
